// File: rtl/fb_arbiter.sv
// Framebuffer port arbiter: scanout reads take priority over queued host pixel writes
// on one single-port RAM, and host strobes cross in through a synchronizer into a small FIFO.
module fb_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_10mhz,
  input  logic                          reset,
  input  logic                          interrupt,
  input  logic [ADDR_W-1:0]             host_addr,
  input  logic [DATA_W-1:0]             host_rgb,
  input  logic                          pix_req,
  input  logic [ADDR_W-1:0]             pix_addr,
  output logic [DATA_W-1:0]             pix_rgb,
  output logic                          pix_valid,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_din,
  output logic                          mem_we,
  input  logic [DATA_W-1:0]             mem_dout,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          wr_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t              r_state;
  logic                r_sync_p0, r_sync_p1, r_sync_p2;
  logic                r_vld_p0, r_vld_p1;
  logic                r_armed;
  logic                r_rd_p1;
  logic [PTR_W:0]      r_wptr, r_rptr;
  logic [ADDR_W-1:0]   r_q_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]   r_q_rgb  [FIFO_DEPTH];

  logic                w_edge, w_empty, w_full, w_pop, w_push, w_drop;
  logic [ADDR_W-1:0]   w_head_addr;
  logic [DATA_W-1:0]   w_head_rgb;

  // Stage p0..p2: synchronizer plus edge flop. Edges are only armed once the
  // synchronized strobe has really been seen low, so a strobe already high at
  // reset release is ignored until it drops and rises again.
  always_ff @(posedge clk_10mhz or posedge reset) begin
    if (reset) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
      r_sync_p2 <= 1'b0;
      r_vld_p0  <= 1'b0;
      r_vld_p1  <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_sync_p0 <= interrupt;
      r_sync_p1 <= r_sync_p0;
      r_sync_p2 <= r_sync_p1;
      r_vld_p0  <= 1'b1;
      r_vld_p1  <= r_vld_p0;
      if (r_vld_p1 && !r_sync_p1) r_armed <= 1'b1;
    end
  end

  assign w_edge = r_armed & r_sync_p1 & ~r_sync_p2;

  assign w_empty     = (r_wptr == r_rptr);
  assign w_full      = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                       (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign w_pop       = ~pix_req & ~w_empty;
  assign w_push      = w_edge & (~w_full | w_pop);
  assign w_drop      = w_edge & w_full & ~w_pop;
  assign w_head_addr = r_q_addr[r_rptr[PTR_W-1:0]];
  assign w_head_rgb  = r_q_rgb[r_rptr[PTR_W-1:0]];
  assign fifo_level  = r_wptr - r_rptr;

  // A push into a full queue with a concurrent pop reuses the head slot; the
  // head is read combinationally before the edge that overwrites it.
  always_ff @(posedge clk_10mhz) begin
    if (w_push) begin
      r_q_addr[r_wptr[PTR_W-1:0]] <= host_addr;
      r_q_rgb[r_wptr[PTR_W-1:0]]  <= host_rgb;
    end
  end

  always_ff @(posedge clk_10mhz or posedge reset) begin
    if (reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      wr_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      if (w_drop) wr_overflow <= 1'b1;
    end
  end

  // Stage p1: RAM port issue (state, address, write strobe).
  // Stage p2: read data returned by the RAM is captured for scanout.
  always_ff @(posedge clk_10mhz or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      mem_addr  <= '0;
      mem_din   <= '0;
      mem_we    <= 1'b0;
      r_rd_p1   <= 1'b0;
      pix_valid <= 1'b0;
      pix_rgb   <= '0;
    end else begin
      r_rd_p1   <= (r_state == RD);
      pix_valid <= r_rd_p1;
      if (r_rd_p1) pix_rgb <= mem_dout;
      if (pix_req) begin
        r_state  <= RD;
        mem_addr <= pix_addr;
        mem_we   <= 1'b0;
      end else if (!w_empty) begin
        r_state  <= WR;
        mem_addr <= w_head_addr;
        mem_din  <= w_head_rgb;
        mem_we   <= 1'b1;
      end else begin
        r_state  <= IDLE;
        mem_we   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// Scoreboard bench for fb_arbiter: expected RAM writes and scanout reads are queued as
// stimulus is driven, and compared against what a negedge monitor collects from the ports.
`timescale 1ns/1ps
module tb_fb_arbiter;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              interrupt;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_rgb;
  logic              pix_req;
  logic [ADDR_W-1:0] pix_addr;
  logic [DATA_W-1:0] pix_rgb;
  logic              pix_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_we;
  logic [DATA_W-1:0] mem_dout = '0;
  logic [LVL_W-1:0]  fifo_level;
  logic              wr_overflow;

  fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_10mhz(clk), .reset(reset), .interrupt(interrupt),
    .host_addr(host_addr), .host_rgb(host_rgb),
    .pix_req(pix_req), .pix_addr(pix_addr),
    .pix_rgb(pix_rgb), .pix_valid(pix_valid),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
    .fifo_level(fifo_level), .wr_overflow(wr_overflow)
  );

  always #50 clk = ~clk;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } xact_t;

  xact_t exp_wr[$];
  xact_t obs_wr[$];
  xact_t exp_rd[$];
  xact_t obs_rd[$];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int last_rise = 0;

  // Registered-read RAM stand-in: read data is the low address bits.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    mem_dout <= mem_addr[DATA_W-1:0];
  end

  always @(negedge clk) begin
    xact_t t;
    if (!reset) begin
      if (mem_we) begin
        t.cyc = cyc; t.a = mem_addr; t.d = mem_din;
        obs_wr.push_back(t);
      end
      if (pix_valid) begin
        t.cyc = cyc; t.a = '0; t.d = pix_rgb;
        obs_rd.push_back(t);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #5;
    end
  endtask

  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input bit expect_push);
    xact_t t;
    host_addr = a;
    host_rgb  = d;
    interrupt = 1'b1;
    last_rise = cyc;
    if (expect_push) begin
      t.cyc = 0; t.a = a; t.d = d;
      exp_wr.push_back(t);
    end
    step(5);
    interrupt = 1'b0;
    step(3);
  endtask

  task automatic wait_wr(input int n, input int budget);
    int i = 0;
    while (obs_wr.size() < n && i < budget) begin
      step(1);
      i++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] got [7];
    string       nm  [7];
    reset = 1'b1; interrupt = 1'b0; pix_req = 1'b0;
    pix_addr = '0; host_addr = '0; host_rgb = '0;
    step(2);
    got[0] = 32'(mem_we);     nm[0] = "reset_mem_we";
    got[1] = 32'(mem_addr);   nm[1] = "reset_mem_addr";
    got[2] = 32'(mem_din);    nm[2] = "reset_mem_din";
    got[3] = 32'(pix_rgb);    nm[3] = "reset_pix_rgb";
    got[4] = 32'(pix_valid);  nm[4] = "reset_pix_valid";
    got[5] = 32'(fifo_level); nm[5] = "reset_fifo_level";
    got[6] = 32'(wr_overflow);nm[6] = "reset_wr_overflow";
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (got[i] !== 32'd0) begin
        n_fail++;
        $display("FAIL %s: got %0h expected 0", nm[i], got[i]);
      end
    end
    reset = 1'b0;
    step(4);
  endtask

  task automatic test_single_write();
    xact_t e, o;
    obs_wr.delete(); exp_wr.delete();
    host_write(15'h0123, 3'd5, 1'b1);
    wait_wr(1, 10);
    step(3);
    n_checks++;
    if (obs_wr.size() !== 1) begin
      n_fail++;
      $display("FAIL single_write_count: got %0d expected 1", obs_wr.size());
    end
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      n_checks++;
      if (obs_wr.size() == 0) begin
        n_fail++;
        $display("FAIL single_write_missing: got none expected addr %0h", e.a);
      end else begin
        o = obs_wr.pop_front();
        if (o.a !== e.a || o.d !== e.d) begin
          n_fail++;
          $display("FAIL single_write_data: got %0h/%0h expected %0h/%0h", o.a, o.d, e.a, e.d);
        end
        n_checks++;
        if (o.cyc - last_rise > 5) begin
          n_fail++;
          $display("FAIL single_write_latency: got %0d clocks expected <= 5", o.cyc - last_rise);
        end
      end
    end
    n_checks++;
    if (fifo_level !== 0) begin
      n_fail++;
      $display("FAIL single_write_level: got %0d expected 0", fifo_level);
    end
  endtask

  task automatic test_read_latency();
    xact_t e, o;
    obs_rd.delete(); exp_rd.delete();
    for (int i = 0; i < 3; i++) begin
      pix_req  = 1'b1;
      pix_addr = ADDR_W'(10 + i);
      // Sampled at the next edge; data valid two edges after that.
      e.cyc = cyc + 3; e.a = '0; e.d = DATA_W'(10 + i);
      exp_rd.push_back(e);
      step(1);
    end
    pix_req = 1'b0;
    step(6);
    while (exp_rd.size() > 0) begin
      e = exp_rd.pop_front();
      n_checks++;
      if (obs_rd.size() == 0) begin
        n_fail++;
        $display("FAIL read_missing: got none expected rgb %0d", e.d);
      end else begin
        o = obs_rd.pop_front();
        if (o.d !== e.d || o.cyc !== e.cyc) begin
          n_fail++;
          $display("FAIL read_data: got rgb %0d at %0d expected rgb %0d at %0d", o.d, o.cyc, e.d, e.cyc);
        end
      end
    end
    n_checks++;
    if (obs_rd.size() !== 0) begin
      n_fail++;
      $display("FAIL read_extra: got %0d extra valids expected 0", obs_rd.size());
    end
    n_checks++;
    if (pix_valid !== 1'b0 || pix_rgb !== 3'd4) begin
      n_fail++;
      $display("FAIL read_hold: got valid %0b rgb %0d expected 0 and 4", pix_valid, pix_rgb);
    end
  endtask

  task automatic test_priority();
    xact_t e, o;
    int d;
    obs_wr.delete(); exp_wr.delete();
    pix_req = 1'b1; pix_addr = '0;
    host_write(15'h0042, 3'd1, 1'b1);
    host_write(15'h1000, 3'd6, 1'b1);
    step(200 - 16);
    n_checks++;
    if (obs_wr.size() !== 0) begin
      n_fail++;
      $display("FAIL priority_no_write: got %0d writes expected 0", obs_wr.size());
    end
    n_checks++;
    if (fifo_level !== 2) begin
      n_fail++;
      $display("FAIL priority_level: got %0d expected 2", fifo_level);
    end
    pix_req = 1'b0;
    d = cyc;
    wait_wr(2, 10);
    step(2);
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      n_checks++;
      if (obs_wr.size() == 0) begin
        n_fail++;
        $display("FAIL priority_missing: got none expected addr %0h", e.a);
      end else begin
        o = obs_wr.pop_front();
        if (o.a !== e.a || o.d !== e.d || o.cyc - d < 1 || o.cyc - d > 2) begin
          n_fail++;
          $display("FAIL priority_write: got %0h/%0h at +%0d expected %0h/%0h at +1..2",
                   o.a, o.d, o.cyc - d, e.a, e.d);
        end
      end
    end
    n_checks++;
    if (obs_wr.size() !== 0) begin
      n_fail++;
      $display("FAIL priority_extra: got %0d extra writes expected 0", obs_wr.size());
    end
    obs_rd.delete();
  endtask

  task automatic test_overflow();
    xact_t e, o;
    obs_wr.delete(); exp_wr.delete();
    pix_req = 1'b1;
    for (int i = 0; i < 5; i++)
      host_write(ADDR_W'(16'h0200 + i), DATA_W'(i + 1), (i < 4));
    n_checks++;
    if (fifo_level !== 4) begin
      n_fail++;
      $display("FAIL overflow_level: got %0d expected 4", fifo_level);
    end
    n_checks++;
    if (wr_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_flag: got %0b expected 1", wr_overflow);
    end
    pix_req = 1'b0;
    wait_wr(4, 12);
    step(3);
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      n_checks++;
      if (obs_wr.size() == 0) begin
        n_fail++;
        $display("FAIL overflow_missing: got none expected addr %0h", e.a);
      end else begin
        o = obs_wr.pop_front();
        if (o.a !== e.a || o.d !== e.d) begin
          n_fail++;
          $display("FAIL overflow_write: got %0h/%0h expected %0h/%0h", o.a, o.d, e.a, e.d);
        end
      end
    end
    n_checks++;
    if (obs_wr.size() !== 0 || wr_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_after: got %0d extra writes flag %0b expected 0 and 1",
               obs_wr.size(), wr_overflow);
    end
    obs_rd.delete();
  endtask

  task automatic test_full_pop();
    xact_t e, o;
    reset = 1'b1;
    step(2);
    n_checks++;
    if (wr_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL fullpop_flag_reset: got %0b expected 0", wr_overflow);
    end
    reset = 1'b0;
    step(4);
    obs_wr.delete(); exp_wr.delete();
    pix_req = 1'b1;
    for (int i = 0; i < 4; i++)
      host_write(ADDR_W'(16'h0300 + i), DATA_W'(7 - i), 1'b1);
    n_checks++;
    if (fifo_level !== 4) begin
      n_fail++;
      $display("FAIL fullpop_level_full: got %0d expected 4", fifo_level);
    end
    host_addr = 15'h0777; host_rgb = 3'd2; interrupt = 1'b1;
    e.cyc = 0; e.a = 15'h0777; e.d = 3'd2;
    exp_wr.push_back(e);
    step(2);
    pix_req = 1'b0;
    step(1);
    n_checks++;
    if (fifo_level !== 4 || wr_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL fullpop_same_cycle: got level %0d flag %0b expected 4 and 0",
               fifo_level, wr_overflow);
    end
    step(2);
    interrupt = 1'b0;
    wait_wr(5, 15);
    step(3);
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      n_checks++;
      if (obs_wr.size() == 0) begin
        n_fail++;
        $display("FAIL fullpop_missing: got none expected addr %0h", e.a);
      end else begin
        o = obs_wr.pop_front();
        if (o.a !== e.a || o.d !== e.d) begin
          n_fail++;
          $display("FAIL fullpop_write: got %0h/%0h expected %0h/%0h", o.a, o.d, e.a, e.d);
        end
      end
    end
    n_checks++;
    if (obs_wr.size() !== 0 || fifo_level !== 0 || wr_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL fullpop_after: got extra %0d level %0d flag %0b expected 0 0 0",
               obs_wr.size(), fifo_level, wr_overflow);
    end
    obs_rd.delete();
  endtask

  task automatic test_reset_mid();
    xact_t e, o;
    obs_wr.delete(); exp_wr.delete();
    pix_req = 1'b1;
    for (int i = 0; i < 3; i++)
      host_write(ADDR_W'(16'h0500 + i), DATA_W'(i), 1'b0);
    n_checks++;
    if (fifo_level !== 3) begin
      n_fail++;
      $display("FAIL resetmid_level: got %0d expected 3", fifo_level);
    end
    pix_req = 1'b0;
    @(posedge clk);
    #10;
    n_checks++;
    if (mem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL resetmid_pop_started: got mem_we %0b expected 1", mem_we);
    end
    reset = 1'b1;
    interrupt = 1'b1;
    #1;
    n_checks++;
    if (mem_we !== 1'b0 || fifo_level !== 0) begin
      n_fail++;
      $display("FAIL resetmid_async: got mem_we %0b level %0d expected 0 and 0", mem_we, fifo_level);
    end
    step(2);
    reset = 1'b0;
    step(10);
    n_checks++;
    if (obs_wr.size() !== 0 || fifo_level !== 0) begin
      n_fail++;
      $display("FAIL resetmid_no_write: got %0d writes level %0d expected 0 and 0",
               obs_wr.size(), fifo_level);
    end
    interrupt = 1'b0;
    step(4);
    host_write(15'h7FFF, 3'd7, 1'b1);
    wait_wr(1, 10);
    step(2);
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      n_checks++;
      if (obs_wr.size() == 0) begin
        n_fail++;
        $display("FAIL resetmid_later_edge: got none expected addr %0h", e.a);
      end else begin
        o = obs_wr.pop_front();
        if (o.a !== e.a || o.d !== e.d) begin
          n_fail++;
          $display("FAIL resetmid_later_write: got %0h/%0h expected %0h/%0h", o.a, o.d, e.a, e.d);
        end
      end
    end
    n_checks++;
    if (obs_wr.size() !== 0) begin
      n_fail++;
      $display("FAIL resetmid_extra: got %0d extra writes expected 0", obs_wr.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_read_latency();
    test_priority();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
